// File: rtl/multicycle_ctrl_unit.sv
// Multicycle control unit: sequences fetch/decode/execute/memory/write-back
// and drives datapath enables, with memory-ready timeout and status reporting.
//
// Ports:
//   CLK, Reset (async, active-low)
//   Opcode, Func, toaccIn, IsZero, MemReady     : instruction fields and status in
//   PCWrite..ALUWrite, ALUCtrl                  : datapath controls out
//   Halted, IllegalOp, MemFault, State          : status out
//   InstrCount                                  : retired instructions (wraps)
module multicycle_ctrl_unit #(
   parameter int OPCODE_W    = 4,
   parameter int FUNC_W      = 4,
   parameter int ALUCTRL_W   = 3,
   parameter int ALU_ADD     = 0,
   parameter int MEM_TIMEOUT = 8,
   parameter int CNT_W       = 16
) (
   input  logic                 CLK,
   input  logic                 Reset,
   input  logic [OPCODE_W-1:0]  Opcode,
   input  logic [FUNC_W-1:0]    Func,
   input  logic                 toaccIn,
   input  logic                 IsZero,
   input  logic                 MemReady,
   output logic                 PCWrite,
   output logic                 IorM,
   output logic                 MemRead,
   output logic                 MemWrite,
   output logic                 IRWrite,
   output logic                 toacc,
   output logic                 ItypeSel,
   output logic                 Asel,
   output logic                 Bsel,
   output logic                 Awrite,
   output logic                 Bwrite,
   output logic                 RegWrite,
   output logic                 IsZeroWrite,
   output logic                 Jcontrol,
   output logic                 ALUWrite,
   output logic [ALUCTRL_W-1:0] ALUCtrl,
   output logic                 Halted,
   output logic                 IllegalOp,
   output logic                 MemFault,
   output logic [3:0]           State,
   output logic [CNT_W-1:0]     InstrCount
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_EXEC   = 4'd2,
      S_ADDR   = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWR  = 4'd5,
      S_WB     = 4'd6,
      S_BRANCH = 4'd7,
      S_JUMP   = 4'd8,
      S_HALT   = 4'd9
   } state_t;

   localparam int WAIT_W = $clog2(MEM_TIMEOUT);
   localparam logic [ALUCTRL_W-1:0] ADD_C = ALUCTRL_W'(ALU_ADD);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   state_t            state;
   state_t            nxt;
   logic [WAIT_W-1:0] wait_cnt;
   logic              acc_q;
   logic              retire;
   logic              waiting;
   logic              timeout;
   logic              op_r, op_i, op_ld, op_st, op_bz, op_j, op_h;
   logic              op_ok;
   logic              unused_func;

   assign unused_func = ^Func;

   assign op_r  = (Opcode == OPCODE_W'(0));
   assign op_i  = (Opcode == OPCODE_W'(1));
   assign op_ld = (Opcode == OPCODE_W'(2));
   assign op_st = (Opcode == OPCODE_W'(3));
   assign op_bz = (Opcode == OPCODE_W'(4));
   assign op_j  = (Opcode == OPCODE_W'(5));
   assign op_h  = &Opcode;
   assign op_ok = op_r | op_i | op_ld | op_st | op_bz | op_j | op_h;

   assign waiting = (state == S_FETCH) || (state == S_MEMRD) ||
                    (state == S_MEMWR);
   // Ready in the last allowed cycle wins, so timeout needs MemReady low.
   assign timeout = waiting && !MemReady && (wait_cnt == WAIT_LAST);

   assign State = state;

   always_comb begin
      nxt    = state;
      retire = 1'b0;
      unique case (state)
         S_FETCH: begin
            if (MemReady) nxt = S_DECODE;
         end
         S_DECODE: begin
            unique case (1'b1)
               op_r, op_i:   nxt = S_EXEC;
               op_ld, op_st: nxt = S_ADDR;
               op_bz:        nxt = S_BRANCH;
               op_j:         nxt = S_JUMP;
               op_h:         nxt = S_HALT;
               default:      nxt = S_FETCH;
            endcase
         end
         S_EXEC: nxt = S_WB;
         S_ADDR: nxt = op_st ? S_MEMWR : S_MEMRD;
         S_MEMRD: begin
            if (MemReady)     nxt = S_WB;
            else if (timeout) nxt = S_FETCH;
         end
         S_MEMWR: begin
            if (MemReady) begin
               nxt    = S_FETCH;
               retire = 1'b1;
            end else if (timeout) begin
               nxt = S_FETCH;
            end
         end
         S_WB, S_BRANCH, S_JUMP: begin
            nxt    = S_FETCH;
            retire = 1'b1;
         end
         S_HALT:  nxt = S_HALT;
         default: nxt = S_FETCH;
      endcase
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state      <= S_FETCH;
         wait_cnt   <= '0;
         acc_q      <= 1'b0;
         InstrCount <= '0;
      end else begin
         state <= nxt;
         // A FETCH timeout keeps the state, so it must clear explicitly.
         if ((nxt != state) || timeout)
            wait_cnt <= '0;
         else if (waiting && !MemReady)
            wait_cnt <= wait_cnt + 1'b1;
         if (state == S_DECODE)
            acc_q <= toaccIn;
         if (retire)
            InstrCount <= InstrCount + CNT_W'(1);
      end
   end

   always_comb begin
      PCWrite     = 1'b0;
      IorM        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      toacc       = 1'b0;
      ItypeSel    = 1'b0;
      Asel        = 1'b0;
      Bsel        = 1'b0;
      Awrite      = 1'b0;
      Bwrite      = 1'b0;
      RegWrite    = 1'b0;
      IsZeroWrite = 1'b0;
      Jcontrol    = 1'b0;
      ALUWrite    = 1'b0;
      ALUCtrl     = '0;
      Halted      = 1'b0;
      IllegalOp   = 1'b0;
      MemFault    = 1'b0;
      // Controls are gated by reset so an abort issues no partial write.
      if (Reset) begin
         unique case (state)
            S_FETCH: begin
               MemRead  = 1'b1;
               ALUCtrl  = ADD_C;
               IRWrite  = MemReady;
               PCWrite  = MemReady;
               MemFault = timeout;
            end
            S_DECODE: begin
               Awrite    = 1'b1;
               Bwrite    = 1'b1;
               IllegalOp = !op_ok;
            end
            S_EXEC: begin
               ALUCtrl  = Func[ALUCTRL_W-1:0];
               ALUWrite = 1'b1;
               ItypeSel = op_i;
               Bsel     = op_i;
            end
            S_ADDR: begin
               ALUCtrl  = ADD_C;
               ItypeSel = 1'b1;
               Bsel     = 1'b1;
               ALUWrite = 1'b1;
            end
            S_MEMRD: begin
               IorM     = 1'b1;
               MemRead  = 1'b1;
               MemFault = timeout;
            end
            S_MEMWR: begin
               IorM     = 1'b1;
               MemWrite = 1'b1;
               MemFault = timeout;
            end
            S_WB: begin
               IsZeroWrite = 1'b1;
               toacc       = acc_q;
               RegWrite    = !acc_q;
               Asel        = op_ld;
            end
            S_BRANCH: PCWrite = IsZero;
            S_JUMP: begin
               Jcontrol = 1'b1;
               PCWrite  = 1'b1;
            end
            S_HALT:  Halted = 1'b1;
            default: ;
         endcase
      end
   end

endmodule
